arb_mux_rr: RTL and testbench



---
 rtl/arb_mux_pkg.sv | 26 ++
 rtl/arb_mux_rr_grant.sv | 17 +
 rtl/arb_mux_rr.sv | 83 ++++++++
 tb/tb_arb_mux_rr.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared types and round-robin search helper for arb_mux_rr and rr_grant.
package arb_mux_pkg;
  localparam int MAX_N = 64;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;
  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } rr_res_t;
  // Search starts just past ptr and wraps, so ptr itself has lowest priority.
  function automatic rr_res_t rr_next(input int n, input logic [5:0] ptr, input logic [MAX_N-1:0] req);
    rr_res_t r;
    int j;
    r = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!r.found && req[j]) begin
          r.found = 1'b1;
          r.idx = j[5:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/arb_mux_rr_grant.sv
// rr_grant: combinational round-robin grant over req, searching upward from ptr+1.
module rr_grant
  import arb_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] ptr,
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] grant,
  output logic             found
);
  rr_res_t r;
  assign r = rr_next(N, 6'(ptr), MAX_N'(req));
  assign grant = r.idx[SEL_W-1:0];
  assign found = r.found;
endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel round-robin arbitrating mux with registered valid/ready output.
// Define ARB_MUX_LOCK_EN to honour in_lock burst locking; otherwise in_lock is ignored.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_lock,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);
  logic [SEL_W-1:0] ptr_q, ptr_d, out_sel_q, out_sel_d, g_rr, g;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, found_rr, found, can_load, accept;
  rr_grant #(.N(N)) u_grant (.ptr(ptr_q), .req(in_valid), .grant(g_rr), .found(found_rr));
`ifdef ARB_MUX_LOCK_EN
  state_e state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic locked;
  assign locked = state_q == ST_LOCKED;
  // While locked only the owner may be granted; an idle owner stalls everyone.
  assign g = locked ? owner_q : g_rr;
  assign found = locked ? in_valid[owner_q] : found_rr;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (accept && !locked && in_lock[g]) begin
      state_d = ST_LOCKED;
      owner_d = g;
    end else if (accept && locked && !in_lock[g]) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^in_lock;
  assign g = g_rr;
  assign found = found_rr;
`endif
  assign can_load = ~out_valid_q | out_ready;
  assign accept = found & can_load;
  assign in_ready = accept ? N'(1) << g : '0;
  always_comb begin
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d = accept ? in_data[int'(g)*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = accept ? g : out_sel_q;
    ptr_d = accept ? g : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      ptr_q <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed stimulus with expected beats queued per instance and checked by negedge monitors.
module tb_arb_mux_rr;
  logic clk = 0, rst = 1;
  logic [3:0] in_valid = '0, in_lock = '0, in_ready;
  logic [127:0] in_data = '0;
  logic out_valid, out_ready = 1;
  logic [31:0] out_data;
  logic [1:0] out_sel;
  logic [1:0] v2 = '0, l2 = '0, r2;
  logic [15:0] d2 = '0;
  logic ov2, or2 = 1, os2;
  logic [7:0] od2;
  int checks = 0, errors = 0;
  logic [33:0] q[$];
  logic [8:0] q2[$];

  arb_mux_rr #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_lock(in_lock),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready));

  arb_mux_rr #(.WIDTH(8), .N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_lock(l2),
    .in_ready(r2), .out_valid(ov2), .out_data(od2), .out_sel(os2),
    .out_ready(or2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat4: unexpected sel %0d data %0h", out_sel, out_data);
      end else begin
        logic [33:0] e;
        e = q.pop_front();
        if ({out_sel, out_data} !== e) begin
          errors++;
          $display("FAIL beat4: got sel %0d data %0h expected sel %0d data %0h", out_sel, out_data, e[33:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && or2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL beat2: unexpected sel %0d data %0h", os2, od2);
      end else begin
        logic [8:0] e;
        e = q2.pop_front();
        if ({os2, od2} !== e) begin
          errors++;
          $display("FAIL beat2: got sel %0d data %0h expected sel %0d data %0h", os2, od2, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a();
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sel", 64'(out_sel), 64'd0);
    rst = 0;
    // Round robin with all channels valid
    load_a();
    in_valid = 4'hF;
    foreach (q[i]) q.delete(i);
    q.push_back({2'd0, 32'hA0});
    q.push_back({2'd1, 32'hA1});
    q.push_back({2'd2, 32'hA2});
    q.push_back({2'd3, 32'hA3});
    q.push_back({2'd0, 32'hA0});
    repeat (5) tick();
    in_valid = '0;
    tick();
    // Backpressure holds the beat and blocks all inputs
    in_valid = 4'hF;
    out_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'hA1);
      chk("stall_ready", 64'(in_ready), 64'h0);
      tick();
    end
    q.push_back({2'd1, 32'hA1});
    q.push_back({2'd2, 32'hA2});
    out_ready = 1;
    #1;
    chk("unstall_ready", 64'(in_ready), 64'h4);
    tick();
    in_valid = '0;
    tick();
    // Single channel streams without bubbles
    in_valid = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      in_data[64 +: 32] = 32'(k);
      q.push_back({2'd2, 32'(k)});
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = '0;
    tick();
`ifdef ARB_MUX_LOCK_EN
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hC0 + i;
    in_valid = 4'b0010; in_data[32 +: 32] = 32'h10; in_lock = 4'b0010;
    q.push_back({2'd1, 32'h10});
    tick();
    in_valid = 4'b0111; in_data[32 +: 32] = 32'h11;
    q.push_back({2'd1, 32'h11});
    tick();
    in_data[32 +: 32] = 32'h12; in_lock = 4'b0000;
    q.push_back({2'd1, 32'h12});
    tick();
    in_valid = 4'b0101;
    q.push_back({2'd2, 32'hC2});
    tick();
    in_valid = 4'b0010; in_data[32 +: 32] = 32'h20; in_lock = 4'b0010;
    q.push_back({2'd1, 32'h20});
    tick();
    in_valid = 4'b0101;
    #1;
    chk("lock_stall_ready", 64'(in_ready), 64'h0);
    tick();
    chk("lock_stall_valid", 64'(out_valid), 64'd0);
    in_valid = 4'b0111; in_data[32 +: 32] = 32'h21; in_lock = 4'b0000;
    q.push_back({2'd1, 32'h21});
    tick();
    in_valid = '0;
    tick();
`endif
    // Asynchronous reset discards a held beat and any lock
    in_valid = 4'b0110; in_lock = 4'b0110; out_ready = 0;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'd0);
    chk("async_rst_sel", 64'(out_sel), 64'd0);
    tick();
    rst = 0;
    in_lock = '0; in_valid = 4'hF; out_ready = 1;
    load_a();
    q.push_back({2'd0, 32'hA0});
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = '0;
    tick();
    // Two-channel instance alternates
    d2 = {8'h51, 8'h50};
    v2 = 2'b11;
    q2.push_back({1'b0, 8'h50});
    q2.push_back({1'b1, 8'h51});
    q2.push_back({1'b0, 8'h50});
    q2.push_back({1'b1, 8'h51});
    repeat (4) tick();
    v2 = '0;
    tick();
    tick();
    chk("queue4_empty", 64'(q.size()), 64'd0);
    chk("queue2_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
